ysyx_22050518_mul_seq: RTL

//   Iterative shift-add multiplier sequencer for the NPC execute stage (RV64M MUL/MULW).

---
 rtl/ysyx_22050518_mul_seq_if.sv | 31 +++
 rtl/ysyx_22050518_mul_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050518_mul_seq_if.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_mul_seq_if
//   Handshake bundle between the EXU issue side, the iterative multiplier and
//   writeback.
//   Issue side     : in_valid, in_ready, in_op_a, in_op_b, in_word
//   Writeback side : out_valid, out_ready, out_result
//   modport slave  : the multiplier (accepts operands, presents the result)
//   modport master : the surrounding pipeline (offers operands, takes result)
// ----------------------------------------------------------------------------
interface ysyx_22050518_mul_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_op_a;
  logic [XLEN-1:0] in_op_b;
  logic            in_word;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport slave (
    input  in_valid, in_op_a, in_op_b, in_word, out_ready,
    output in_ready, out_valid, out_result
  );

  modport master (
    output in_valid, in_op_a, in_op_b, in_word, out_ready,
    input  in_ready, out_valid, out_result
  );
endinterface

// File: rtl/ysyx_22050518_mul_seq.sv
// ----------------------------------------------------------------------------
// ysyx_22050518_mul_seq
//   Iterative shift-add multiplier for RV64M MUL/MULW. One partial product is
//   accumulated per cycle through the shared ripple adder of the execute stage.
//   The result is the low XLEN bits of the product; MULW results are
//   sign-extended from bit 31.
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   flush      : synchronous abort of any operation in flight
//   bus        : issue/writeback handshake bundle (slave side)
//   busy       : an operation is in flight or waiting in writeback
//   add_in1/2  : operands to the shared adder (accumulator, shifted mcand)
//   add_cin    : adder carry-in, always 0
//   add_out    : combinational sum returned by the shared adder
// ----------------------------------------------------------------------------
module ysyx_22050518_mul_seq #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  ysyx_22050518_mul_seq_if.slave    bus,
  output logic                      busy,
  output logic [XLEN-1:0]           add_in1,
  output logic [XLEN-1:0]           add_in2,
  output logic                      add_cin,
  input  logic [XLEN-1:0]           add_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_q, word_d;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic              busy_q, busy_d;

  logic [XLEN-1:0]   eff_b_s;

  // Shape the accumulator into the architectural result (MULW sign-extends).
  function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] acc,
                                                 input logic            word);
    logic [XLEN-1:0] res;
    if (word) begin
      res = {{(XLEN-32){acc[31]}}, acc[31:0]};
    end else begin
      res = acc;
    end
    return res;
  endfunction

  // MULW only multiplies by the low word, so the upper multiplier bits are zeroed.
  assign eff_b_s = bus.in_word ? {{(XLEN-32){1'b0}}, bus.in_op_b[31:0]} : bus.in_op_b;

  assign add_in1        = acc_q;
  assign add_in2        = mcand_q;
  assign add_cin        = 1'b0;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign busy           = busy_q;

  // Next-state, datapath update and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    word_d   = word_q;

    if (flush) begin
      // Abort wins over accept and over the writeback handshake.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc_d    = '0;
            mcand_d  = bus.in_op_a;
            mplier_d = eff_b_s;
            word_d   = bus.in_word;
            cnt_d    = '0;
            if (eff_b_s == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mplier_q[0]) begin
            acc_d = add_out;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // Stop as soon as no set multiplier bits remain above the current one.
          if (((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(XLEN-1))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    if (state_d == ST_DONE) begin
      out_result_d = fmt_result(acc_d, word_d);
    end else begin
      out_result_d = '0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      word_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

endmodule
